// File: rtl/light_pkg.sv
// Shared definitions for the light path: ramp FSM state encoding, step-tick
// sizing helpers and width-parameterised saturating arithmetic.
package light_pkg;

  // Ramp FSM state encoding.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2
  } state_e;

  // Width of the carrier used by the saturating helpers; callers cast in/out.
  localparam int unsigned SAT_W = 32;

  // Clock cycles per ramp step.
  function automatic int unsigned ticks_f(input int unsigned clock_freq_mhz,
                                          input int unsigned step_period_us);
    return clock_freq_mhz * step_period_us;
  endfunction

  // Tick counter width; a one-cycle step period still needs a 1-bit counter.
  function automatic int unsigned cnt_width_f(input int unsigned ticks);
    return (ticks > 1) ? 32'($clog2(ticks)) : 32'd1;
  endfunction

  // a + b clamped to 2^width - 1; the sum carries one extra bit so it cannot wrap.
  function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                               input logic [SAT_W-1:0] b,
                                               input int unsigned      width);
    logic [SAT_W:0] sum;
    logic [SAT_W:0] max_v;
    sum   = {1'b0, a} + {1'b0, b};
    max_v = ((SAT_W+1)'(1) << width) - (SAT_W+1)'(1);
    return (sum > max_v) ? max_v[SAT_W-1:0] : sum[SAT_W-1:0];
  endfunction

  // a - b clamped to 0; underflow is detected before subtracting.
  function automatic logic [SAT_W-1:0] sat_sub(input logic [SAT_W-1:0] a,
                                               input logic [SAT_W-1:0] b);
    return (a < b) ? '0 : (a - b);
  endfunction

endpackage

// File: rtl/step_tick_gen.sv
// Ramp step timebase: counts 0..TICKS-1 while enabled and pulses tick_o for
// one cycle at TICKS-1, then wraps to 0.
// Ports: clk_i/rst_i (async active-high), clear_i forces the count to 0,
// enable_i advances the count, tick_o step pulse.
module step_tick_gen
  import light_pkg::*;
#(
  parameter int unsigned TICKS = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic tick_o
);

  localparam int unsigned       CNT_W = cnt_width_f(TICKS);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TICKS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick_o = enable_i && (cnt_q == LAST);

  // Next count: clear wins, otherwise advance and wrap on the tick.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = tick_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/brightness_sequencer.sv
// Brightness sequencer between the encoder decoder and pwm_gen. Encoder steps
// and preset loads update a shared target; value_o fades toward it one LSB per
// step period.
// Ports: clk_i/rst_i (async active-high); inc_i/dec_i encoder pulses;
// preset_valid_i/preset_value_i/preset_ready_o preset handshake (ready only
// in IDLE); value_o PWM value; target_o current target; busy_o ramp active.
module brightness_sequencer
  import light_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ_MHZ = 100,
  parameter int unsigned STEP_PERIOD_US = 1000,
  parameter int unsigned VALUE_SIZE     = 8,
  parameter int unsigned BRIGHTNESS_INC = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  inc_i,
  input  logic                  dec_i,
  input  logic                  preset_valid_i,
  input  logic [VALUE_SIZE-1:0] preset_value_i,
  output logic                  preset_ready_o,
  output logic [VALUE_SIZE-1:0] value_o,
  output logic [VALUE_SIZE-1:0] target_o,
  output logic                  busy_o
);

  localparam int unsigned      TICKS = ticks_f(CLOCK_FREQ_MHZ, STEP_PERIOD_US);
  localparam logic [SAT_W-1:0] INC_W = SAT_W'(BRIGHTNESS_INC);

  state_e                state_q, state_d;
  logic [VALUE_SIZE-1:0] value_q, value_d;
  logic [VALUE_SIZE-1:0] target_q, target_d;
  logic                  busy_q, busy_d;
  logic                  preset_acc;
  logic                  tick;

  // Counter idles at 0 and restarts from 0 on every IDLE->RAMP entry.
  step_tick_gen #(
    .TICKS (TICKS)
  ) u_step_tick_gen (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (state_q == IDLE),
    .enable_i (state_q != IDLE),
    .tick_o   (tick)
  );

  assign preset_ready_o = (state_q == IDLE);

  // Target update, ramp step and next state from next-cycle target vs value.
  always_comb begin
    target_d   = target_q;
    value_d    = value_q;
    state_d    = state_q;
    busy_d     = busy_q;
    preset_acc = preset_valid_i && (state_q == IDLE);

    // Preset beats encoder; opposing encoder pulses cancel.
    if (preset_acc) begin
      target_d = preset_value_i;
    end else if (inc_i && !dec_i) begin
      target_d = VALUE_SIZE'(sat_add(SAT_W'(target_q), INC_W, VALUE_SIZE));
    end else if (dec_i && !inc_i) begin
      target_d = VALUE_SIZE'(sat_sub(SAT_W'(target_q), INC_W));
    end

    if (tick) begin
      case (state_q)
        RAMP_UP:   value_d = value_q + VALUE_SIZE'(1);
        RAMP_DOWN: value_d = value_q - VALUE_SIZE'(1);
        default:   value_d = value_q;
      endcase
    end

    // Comparing against the stepped value lets the final step land in IDLE.
    if (target_d > value_d) begin
      state_d = RAMP_UP;
    end else if (target_d < value_d) begin
      state_d = RAMP_DOWN;
    end else begin
      state_d = IDLE;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      value_q  <= '0;
      target_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      value_q  <= value_d;
      target_q <= target_d;
      busy_q   <= busy_d;
    end
  end

  assign value_o  = value_q;
  assign target_o = target_q;
  assign busy_o   = busy_q;

endmodule

// File: tb/tb_brightness_sequencer.sv
// Directed bench for brightness_sequencer with TICKS=4, VALUE_SIZE=8, INC=5.
// Expected values come from a small target model and are queued when stimulus
// is driven, then popped when the corresponding output is sampled.
module tb_brightness_sequencer;

  logic       clk;
  logic       rst;
  logic       inc;
  logic       dec;
  logic       pv;
  logic [7:0] pval;
  logic       ready;
  logic [7:0] value;
  logic [7:0] target;
  logic       busy;

  int         checks;
  int         errors;
  string      tag_q[$];
  logic [31:0] exp_q[$];
  int         mdl_target;
  int         n;
  logic       track_max;
  int         max_seen;

  brightness_sequencer #(
    .CLOCK_FREQ_MHZ (1),
    .STEP_PERIOD_US (4),
    .VALUE_SIZE     (8),
    .BRIGHTNESS_INC (5)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .inc_i          (inc),
    .dec_i          (dec),
    .preset_valid_i (pv),
    .preset_value_i (pval),
    .preset_ready_o (ready),
    .value_o        (value),
    .target_o       (target),
    .busy_o         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (track_max && (int'(value) > max_seen)) max_seen = int'(value);
  end

  function automatic int mdl_inc(input int t);
    return (t + 5 > 255) ? 255 : t + 5;
  endfunction

  function automatic int mdl_dec(input int t);
    return (t < 5) ? 0 : t - 5;
  endfunction

  function automatic void push_exp(input string tag, input int v);
    tag_q.push_back(tag);
    exp_q.push_back(32'(v));
  endfunction

  task automatic chk(input logic [31:0] observed);
    string       tag;
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%0d expected=none", observed);
    end else begin
      tag = tag_q.pop_front();
      e   = exp_q.pop_front();
      assert (observed === e) else begin
        errors++;
        $error("FAIL %s observed=%0d expected=%0d", tag, observed, e);
      end
    end
  endtask

  task automatic timeout_fail(input string tag);
    checks++;
    errors++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic i, input logic d);
    inc = i;
    dec = d;
    step();
    inc = 1'b0;
    dec = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < budget) begin
      step();
      k++;
    end
    if (busy !== 1'b0) timeout_fail(tag);
  endtask

  task automatic wait_value(input string tag, input int v, input int budget);
    int k;
    k = 0;
    while (int'(value) != v && k < budget) begin
      step();
      k++;
    end
    if (int'(value) != v) timeout_fail(tag);
  endtask

  task automatic load_preset(input int v);
    pv   = 1'b1;
    pval = 8'(v);
    step();
    pv   = 1'b0;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    mdl_target = 0;
    track_max  = 1'b0;
    max_seen   = 0;
    rst  = 1'b1;
    inc  = 1'b0;
    dec  = 1'b0;
    pv   = 1'b0;
    pval = 8'd0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    push_exp("reset_value", 0);  chk(32'(value));
    push_exp("reset_target", 0); chk(32'(target));
    push_exp("reset_busy", 0);   chk(32'(busy));
    push_exp("reset_ready", 1);  chk(32'(ready));
    rst = 1'b0;
    step();

    // Single inc from reset: one LSB every 4 cycles up to 5
    mdl_target = mdl_inc(mdl_target);
    pulse(1'b1, 1'b0);
    push_exp("inc_target", mdl_target); chk(32'(target));
    push_exp("inc_busy", 1);            chk(32'(busy));
    push_exp("inc_ready", 0);           chk(32'(ready));
    for (int k = 1; k <= 5; k++) begin
      repeat (3) step();
      push_exp("ramp_hold", k - 1); chk(32'(value));
      step();
      push_exp("ramp_step", k);     chk(32'(value));
    end
    push_exp("ramp_done_busy", 0);  chk(32'(busy));
    push_exp("ramp_done_ready", 1); chk(32'(ready));

    // Saturation at the top and bottom of the range
    mdl_target = 253;
    load_preset(253);
    push_exp("sat_preset_target", mdl_target); chk(32'(target));
    wait_idle("sat_wait_253", 1500);
    push_exp("sat_value_253", 253); chk(32'(value));
    mdl_target = mdl_inc(mdl_target);
    pulse(1'b1, 1'b0);
    push_exp("sat_inc_target", mdl_target); chk(32'(target));
    wait_idle("sat_wait_255", 100);
    push_exp("sat_value_255", 255); chk(32'(value));
    mdl_target = 3;
    load_preset(3);
    push_exp("sat_preset3_target", mdl_target); chk(32'(target));
    wait_idle("sat_wait_3", 1500);
    mdl_target = mdl_dec(mdl_target);
    pulse(1'b0, 1'b1);
    push_exp("sat_dec_target", mdl_target); chk(32'(target));
    wait_idle("sat_wait_0", 100);
    push_exp("sat_value_0", 0); chk(32'(value));

    // Preset held during a ramp is taken on the first IDLE cycle
    mdl_target = mdl_inc(mdl_target);
    pulse(1'b1, 1'b0);
    pv   = 1'b1;
    pval = 8'd100;
    n    = 0;
    while (ready !== 1'b1 && n < 100) begin
      step();
      n++;
      if (ready !== 1'b1) begin
        push_exp("hs_hold_target", mdl_target); chk(32'(target));
      end
    end
    if (ready !== 1'b1) timeout_fail("hs_wait_ready");
    push_exp("hs_idle_target", mdl_target); chk(32'(target));
    mdl_target = 100;
    step();
    pv = 1'b0;
    push_exp("hs_accept_target", mdl_target); chk(32'(target));
    push_exp("hs_accept_busy", 1);            chk(32'(busy));
    wait_idle("hs_wait_100", 1000);
    push_exp("hs_value_100", 100); chk(32'(value));

    // Preset wins over a same-cycle inc; inc+dec cancel
    pv   = 1'b1;
    pval = 8'd50;
    inc  = 1'b1;
    mdl_target = 50;
    step();
    pv  = 1'b0;
    inc = 1'b0;
    push_exp("simul_preset_target", mdl_target); chk(32'(target));
    wait_idle("simul_wait_50", 500);
    pulse(1'b1, 1'b1);
    push_exp("simul_incdec_target", mdl_target); chk(32'(target));
    push_exp("simul_incdec_busy", 0);            chk(32'(busy));

    // Reversal mid-ramp: no overshoot past 3
    mdl_target = 0;
    load_preset(0);
    wait_idle("rev_wait_0", 500);
    push_exp("rev_start_value", 0); chk(32'(value));
    max_seen  = 0;
    track_max = 1'b1;
    mdl_target = mdl_inc(mdl_target);
    pulse(1'b1, 1'b0);
    step();
    mdl_target = mdl_inc(mdl_target);
    pulse(1'b1, 1'b0);
    push_exp("rev_up_target", mdl_target); chk(32'(target));
    wait_value("rev_wait_3", 3, 100);
    mdl_target = mdl_dec(mdl_target);
    pulse(1'b0, 1'b1);
    step();
    mdl_target = mdl_dec(mdl_target);
    pulse(1'b0, 1'b1);
    push_exp("rev_down_target", mdl_target); chk(32'(target));
    step();
    push_exp("rev_value_2", 2); chk(32'(value));
    repeat (4) step();
    push_exp("rev_value_1", 1); chk(32'(value));
    repeat (4) step();
    push_exp("rev_value_0", 0); chk(32'(value));
    push_exp("rev_done_busy", 0); chk(32'(busy));
    track_max = 1'b0;
    push_exp("rev_max_value", 3); chk(32'(max_seen));

    // Asynchronous reset mid-ramp at value 7
    mdl_target = 20;
    load_preset(20);
    wait_value("rst_wait_7", 7, 100);
    #2;
    rst = 1'b1;
    #1;
    mdl_target = 0;
    push_exp("rst_value", 0);  chk(32'(value));
    push_exp("rst_target", 0); chk(32'(target));
    push_exp("rst_busy", 0);   chk(32'(busy));
    push_exp("rst_ready", 1);  chk(32'(ready));
    step();
    step();
    rst = 1'b0;
    step();
    push_exp("post_rst_value", 0); chk(32'(value));
    mdl_target = mdl_inc(mdl_target);
    pulse(1'b1, 1'b0);
    push_exp("post_rst_inc_target", mdl_target); chk(32'(target));
    push_exp("post_rst_inc_busy", 1);            chk(32'(busy));

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
